// File: rtl/sseg_scan_rx_if.sv
// Seven-segment scan bus (an/seg/dp, active-low) plus the decoded-frame results seen by the receiver.
// Master drives the scanned lines and observes the frame; slave is the receiver.
interface sseg_scan_rx_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] digits;
  logic [3:0]  dps;
  logic [3:0]  blank;
  logic [3:0]  bad;
  logic        frame_valid;
  logic        idle;

  modport master (
    output an, seg, dp,
    input  digits, dps, blank, bad, frame_valid, idle
  );

  modport slave (
    input  an, seg, dp,
    output digits, dps, blank, bad, frame_valid, idle
  );
endinterface

// File: rtl/sseg_scan_rx.sv
// Passive receiver for a 4-digit multiplexed seven-segment bus: samples settled digits, decodes to hex, reassembles frames.
// Sample-to-frame output latency 1 cycle; no backpressure, the bus is only observed.
module sseg_scan_rx #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1_000_000
) (
  input logic           clk,
  input logic           rst_n,
  sseg_scan_rx_if.slave bus
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE);
  localparam logic [IW-1:0] TIMEOUT_C = IW'(TIMEOUT);

  typedef enum logic [1:0] {ST_GAP, ST_SETTLING, ST_HOLD} state_e;

  typedef struct packed {
    logic       bad;
    logic       blank;
    logic [3:0] nib;
  } dec_t;

  // Input is the active-high gfedcba pattern.
  function automatic dec_t decode(input logic [6:0] seg_h);
    dec_t r;
    r.bad   = 1'b0;
    r.blank = 1'b0;
    r.nib   = 4'h0;
    case (seg_h)
      7'h3F: r.nib = 4'h0;
      7'h06: r.nib = 4'h1;
      7'h5B: r.nib = 4'h2;
      7'h4F: r.nib = 4'h3;
      7'h66: r.nib = 4'h4;
      7'h6D: r.nib = 4'h5;
      7'h7D: r.nib = 4'h6;
      7'h07: r.nib = 4'h7;
      7'h7F: r.nib = 4'h8;
      7'h6F: r.nib = 4'h9;
      7'h77: r.nib = 4'hA;
      7'h7C: r.nib = 4'hB;
      7'h39: r.nib = 4'hC;
      7'h5E: r.nib = 4'hD;
      7'h79: r.nib = 4'hE;
      7'h71: r.nib = 4'hF;
      7'h00: r.blank = 1'b1;
      default: r.bad = 1'b1;
    endcase
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [11:0]     prev_q, prev_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0]      coll_q, coll_d;
  logic [3:0][3:0] sh_nib_q, sh_nib_d;
  logic [3:0]      sh_dp_q, sh_dp_d;
  logic [3:0]      sh_blank_q, sh_blank_d;
  logic [3:0]      sh_bad_q, sh_bad_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [15:0]     digits_q, digits_d;
  logic [3:0]      dps_q, dps_d;
  logic [3:0]      blank_q, blank_d;
  logic [3:0]      bad_q, bad_d;
  logic            frame_valid_q, frame_valid_d;
  logic            idle_q, idle_d;

  logic [11:0]     cur;
  logic [3:0]      an_low;
  logic            is_gap;
  logic            is_onehot;
  logic            changed;
  logic [1:0]      idx;
  logic [CW-1:0]   cnt_next;
  logic            sample;
  dec_t            dec;

  assign cur       = {bus.an, bus.seg, bus.dp};
  assign an_low    = ~bus.an;
  assign is_gap    = (an_low == 4'h0);
  assign is_onehot = $onehot(an_low);
  assign changed   = (cur != prev_q);
  assign dec       = decode(~bus.seg);

  always_comb begin
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (an_low[i]) idx = 2'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    prev_d        = cur;
    mask_d        = mask_q;
    coll_d        = coll_q;
    sh_nib_d      = sh_nib_q;
    sh_dp_d       = sh_dp_q;
    sh_blank_d    = sh_blank_q;
    sh_bad_d      = sh_bad_q;
    idle_cnt_d    = idle_cnt_q;
    digits_d      = digits_q;
    dps_d         = dps_q;
    blank_d       = blank_q;
    bad_d         = bad_q;
    frame_valid_d = 1'b0;
    sample        = 1'b0;

    // First cycle of a new value counts as 1, so a sample lands on its SETTLE-th cycle.
    cnt_next = ((state_q == ST_GAP) || changed) ? CW'(1) : cnt_q + CW'(1);

    if (is_gap) begin
      state_d = ST_GAP;
      cnt_d   = '0;
    end else if (!is_onehot) begin
      state_d = ST_GAP;
      cnt_d   = '0;
      coll_d  = coll_q | an_low;
    end else if ((state_q == ST_HOLD) && !changed) begin
      state_d = ST_HOLD;
    end else begin
      cnt_d = cnt_next;
      if (cnt_next == SETTLE_C) begin
        sample  = 1'b1;
        state_d = ST_HOLD;
      end else begin
        state_d = ST_SETTLING;
      end
    end

    if (sample) begin
      sh_nib_d[idx]   = dec.nib;
      sh_dp_d[idx]    = ~bus.dp;
      sh_blank_d[idx] = dec.blank;
      sh_bad_d[idx]   = dec.bad;
      mask_d[idx]     = 1'b1;
    end

    if (sample) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != TIMEOUT_C) begin
      idle_cnt_d = idle_cnt_q + IW'(1);
    end

    // A long silence abandons the partial frame; the last published frame stays visible.
    if (!sample && (idle_cnt_d == TIMEOUT_C)) begin
      mask_d = 4'h0;
      coll_d = 4'h0;
    end
    idle_d = (idle_cnt_d == TIMEOUT_C);

    if (sample && (mask_d == 4'hF)) begin
      digits_d      = sh_nib_d;
      dps_d         = sh_dp_d;
      blank_d       = sh_blank_d;
      bad_d         = sh_bad_d | coll_d;
      frame_valid_d = 1'b1;
      mask_d        = 4'h0;
      coll_d        = 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_GAP;
      cnt_q         <= '0;
      prev_q        <= '0;
      mask_q        <= '0;
      coll_q        <= '0;
      sh_nib_q      <= '0;
      sh_dp_q       <= '0;
      sh_blank_q    <= '0;
      sh_bad_q      <= '0;
      idle_cnt_q    <= '0;
      digits_q      <= '0;
      dps_q         <= '0;
      blank_q       <= '0;
      bad_q         <= '0;
      frame_valid_q <= 1'b0;
      idle_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prev_q        <= prev_d;
      mask_q        <= mask_d;
      coll_q        <= coll_d;
      sh_nib_q      <= sh_nib_d;
      sh_dp_q       <= sh_dp_d;
      sh_blank_q    <= sh_blank_d;
      sh_bad_q      <= sh_bad_d;
      idle_cnt_q    <= idle_cnt_d;
      digits_q      <= digits_d;
      dps_q         <= dps_d;
      blank_q       <= blank_d;
      bad_q         <= bad_d;
      frame_valid_q <= frame_valid_d;
      idle_q        <= idle_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.dps         = dps_q;
  assign bus.blank       = blank_q;
  assign bus.bad         = bad_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.idle        = idle_q;

endmodule

// File: tb/tb_sseg_scan_rx.sv
// Directed bench for sseg_scan_rx: table of full frames plus hand sequences for settle, timeout and reset.
module tb_sseg_scan_rx;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sseg_scan_rx_if bus ();

  sseg_scan_rx #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  int          fv_count = 0;
  logic [15:0] cap_digits = '0;
  logic [3:0]  cap_dps = '0;
  logic [3:0]  cap_blank = '0;
  logic [3:0]  cap_bad = '0;

  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) begin
      fv_count++;
      cap_digits = bus.digits;
      cap_dps    = bus.dps;
      cap_blank  = bus.blank;
      cap_bad    = bus.bad;
    end
  end

  typedef struct {
    string           name;
    logic [3:0][6:0] seg_n;
    logic [3:0]      dp_n;
    logic [3:0]      coll_an;
    logic [15:0]     e_digits;
    logic [3:0]      e_dps;
    logic [3:0]      e_blank;
    logic [3:0]      e_bad;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    bus.an  = an;
    bus.seg = seg;
    bus.dp  = dp;
  endtask

  task automatic gap(input int n);
    bus.an = 4'hF;
    tick(n);
  endtask

  task automatic scan_digit(input int idx, input logic [6:0] seg, input logic dp);
    logic [3:0] one;
    one = 4'b0001 << idx;
    present(~one, seg, dp);
    tick(8);
    gap(2);
  endtask

  initial begin
    int fv0;

    // Segment codes below are active-low.
    vecs[0] = '{"t2_1234", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'hF, 16'h1234, 4'h0, 4'h0, 4'h0};
    vecs[1] = '{"t4_blank8", {7'h40, 7'h7F, 7'h00, 7'h12}, 4'b1101, 4'hF, 16'h0085, 4'b0010, 4'b0100, 4'h0};
    vecs[2] = '{"hex_abcd", {7'h08, 7'h03, 7'h46, 7'h21}, 4'h0, 4'hF, 16'hABCD, 4'hF, 4'h0, 4'h0};
    vecs[3] = '{"hex_ef97", {7'h06, 7'h0E, 7'h10, 7'h78}, 4'hF, 4'hF, 16'hEF97, 4'h0, 4'h0, 4'h0};
    vecs[4] = '{"bad_coll", {7'h7E, 7'h02, 7'h40, 7'h79}, 4'hF, 4'b0011, 16'h0601, 4'h0, 4'h0, 4'b1100};
    vecs[5] = '{"dp_5432", {7'h12, 7'h19, 7'h30, 7'h24}, 4'b0110, 4'hF, 16'h5432, 4'b1001, 4'h0, 4'h0};

    // T1: reset with random bus activity
    rst_n = 1'b0;
    repeat (3) begin
      present(4'($urandom), 7'($urandom), 1'($urandom));
      tick(1);
    end
    check("rst_digits", 32'(bus.digits), 32'h0);
    check("rst_dps", 32'(bus.dps), 32'h0);
    check("rst_blank", 32'(bus.blank), 32'h0);
    check("rst_bad", 32'(bus.bad), 32'h0);
    check("rst_fv", 32'(bus.frame_valid), 32'h0);
    check("rst_idle", 32'(bus.idle), 32'h0);
    present(4'hF, 7'h7F, 1'b1);
    rst_n = 1'b1;
    gap(2);

    // Table-driven full frames
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].coll_an != 4'hF) begin
        present(vecs[v].coll_an, 7'h7F, 1'b1);
        tick(6);
        gap(2);
      end
      fv0 = fv_count;
      for (int d = 3; d >= 0; d--) scan_digit(d, vecs[v].seg_n[d], vecs[v].dp_n[d]);
      tick(2);
      check({vecs[v].name, "_frames"}, 32'(fv_count - fv0), 32'd1);
      check({vecs[v].name, "_digits"}, 32'(cap_digits), 32'(vecs[v].e_digits));
      check({vecs[v].name, "_dps"}, 32'(cap_dps), 32'(vecs[v].e_dps));
      check({vecs[v].name, "_blank"}, 32'(cap_blank), 32'(vecs[v].e_blank));
      check({vecs[v].name, "_bad"}, 32'(cap_bad), 32'(vecs[v].e_bad));
    end

    // T3: glitches restart the settle count; the final stable pattern is captured
    scan_digit(3, 7'h79, 1'b1);
    scan_digit(2, 7'h24, 1'b1);
    scan_digit(1, 7'h30, 1'b1);
    present(4'b1110, 7'h79, 1'b1);
    tick(2);
    present(4'b1110, 7'h24, 1'b1);
    tick(2);
    present(4'b1110, 7'h10, 1'b1);
    tick(3);
    check("settle_early", 32'(bus.frame_valid), 32'h0);
    tick(1);
    check("settle_sample", 32'(bus.frame_valid), 32'h1);
    check("settle_digits", 32'(bus.digits), 32'h1239);
    tick(1);
    check("fv_pulse_width", 32'(bus.frame_valid), 32'h0);
    gap(2);

    // T5: timeout drops the partial frame
    scan_digit(3, 7'h78, 1'b1);
    scan_digit(2, 7'h78, 1'b1);
    tick(43);
    check("idle_before", 32'(bus.idle), 32'h0);
    tick(1);
    check("idle_at_timeout", 32'(bus.idle), 32'h1);
    check("idle_digits_hold", 32'(bus.digits), 32'h1239);
    fv0 = fv_count;
    present(4'b1101, 7'h12, 1'b1);
    tick(3);
    check("idle_hold", 32'(bus.idle), 32'h1);
    tick(1);
    check("idle_drop", 32'(bus.idle), 32'h0);
    tick(4);
    gap(2);
    scan_digit(0, 7'h02, 1'b1);
    check("timeout_mask_cleared", 32'(fv_count - fv0), 32'd0);
    scan_digit(3, 7'h08, 1'b1);
    scan_digit(2, 7'h03, 1'b1);
    check("timeout_frames", 32'(fv_count - fv0), 32'd1);
    check("timeout_digits", 32'(cap_digits), 32'hAB56);

    // T6: reset mid-frame discards the partial frame
    fv0 = fv_count;
    scan_digit(3, 7'h79, 1'b1);
    scan_digit(2, 7'h24, 1'b1);
    scan_digit(1, 7'h30, 1'b1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("rstmid_digits", 32'(bus.digits), 32'h0);
    check("rstmid_idle", 32'(bus.idle), 32'h0);
    gap(2);
    scan_digit(0, 7'h19, 1'b1);
    check("rstmid_partial", 32'(fv_count - fv0), 32'd0);
    scan_digit(3, 7'h00, 1'b1);
    scan_digit(2, 7'h10, 1'b1);
    scan_digit(1, 7'h40, 1'b1);
    check("rstmid_frames", 32'(fv_count - fv0), 32'd1);
    check("rstmid_new_digits", 32'(cap_digits), 32'h8904);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
